// File: rtl/raster_streamer_pkg.sv
// Shared types and helpers for the raster frame-source sequencer.
package raster_streamer_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_PRIME,
    RS_STREAM,
    RS_FLUSH,
    RS_DONE
  } rs_state_e;

  function automatic logic [COORD_W-1:0] coord(input int v);
    return COORD_W'(v);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter; x wraps at FRAME_WIDTH and carries into y.
module raster_counter
  import raster_streamer_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv_i) begin
      if (x_q == coord(FRAME_WIDTH - 1)) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == coord(FRAME_WIDTH - 1)) && (y_q == coord(FRAME_HEIGHT - 1));

endmodule

// File: rtl/raster_streamer.sv
// Reads a frame from one-cycle-latency memory in raster order, emits one beat
// per unstalled cycle, then appends zero flush beats before pulsing done.
module raster_streamer
  import raster_streamer_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 19,
  parameter int PIXEL_SIZE   = 24,
  parameter int FLUSH_CYCLES = FRAME_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic                  en,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  done
);

  rs_state_e             state_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  en_q;
  logic                  zero_q;
  logic [COORD_W-1:0]    x_q;
  logic [COORD_W-1:0]    y_q;
  logic [PIXEL_SIZE-1:0] data_q;
  logic                  busy_q;
  logic                  done_q;

  logic               cnt_clr_d;
  logic               issue_d;
  logic               flush_end_d;
  logic [COORD_W-1:0] cnt_x;
  logic [COORD_W-1:0] cnt_y;
  logic               cnt_last;

  // The counter is cleared on entry to FLUSH and then counts flush beats;
  // flush is complete once it has advanced FLUSH_CYCLES times.
  assign flush_end_d = (cnt_y == coord(FLUSH_CYCLES / FRAME_WIDTH)) &&
                       (cnt_x == coord(FLUSH_CYCLES % FRAME_WIDTH));
  assign issue_d     = !stall && ((state_q == RS_STREAM) ||
                                  (state_q == RS_FLUSH && !flush_end_d));
  assign cnt_clr_d   = (state_q == RS_IDLE && start) ||
                       (state_q == RS_STREAM && issue_d && cnt_last);

  raster_counter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr_d),
    .adv_i (issue_d),
    .x_o   (cnt_x),
    .y_o   (cnt_y),
    .last_o(cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RS_IDLE;
      mem_addr_q <= '0;
      en_q       <= 1'b0;
      zero_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      en_q   <= issue_d;
      zero_q <= issue_d && (state_q == RS_FLUSH);
      data_q <= data;
      done_q <= 1'b0;
      if (issue_d) begin
        x_q <= cnt_x;
        y_q <= (state_q == RS_FLUSH) ? coord(FRAME_HEIGHT) : cnt_y;
      end
      case (state_q)
        RS_IDLE: begin
          if (start) begin
            state_q    <= RS_PRIME;
            mem_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        RS_PRIME: state_q <= RS_STREAM;
        RS_STREAM: begin
          if (issue_d) begin
            if (cnt_last) state_q <= RS_FLUSH;
            else          mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        RS_FLUSH: begin
          if (flush_end_d) begin
            state_q <= RS_DONE;
            done_q  <= 1'b1;
          end
        end
        RS_DONE: begin
          state_q <= RS_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= RS_IDLE;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign en       = en_q;
  assign x        = x_q;
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data     = en_q ? (zero_q ? '0 : mem_data) : data_q;

endmodule

// File: tb/tb_raster_streamer.sv
// Scoreboard bench for raster_streamer on a 4x3 frame with address-valued memory.
module tb_raster_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FC = 6;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  mem_addr;
  logic [23:0] mem_data;
  logic        en;
  logic [15:0] x;
  logic [15:0] y;
  logic [23:0] data;
  logic        busy;
  logic        done;

  raster_streamer #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .ADDR_WIDTH  (4),
    .PIXEL_SIZE  (24),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stall   (stall),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .en      (en),
    .x       (x),
    .y       (y),
    .data    (data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Frame memory: word value equals its address, one-cycle read latency.
  always @(posedge clk) mem_data <= {20'd0, mem_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int data;
    int cyc;
  } beat_t;

  beat_t beat_q[$];
  int    done_q[$];
  int    vectors = 0;
  int    misses  = 0;
  int    beat_no = 0;

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Beat j nominally appears at first+j; beats issued on or after stall_at slip by nstall.
  task automatic push_frame(input int first, input int stall_at, input int nstall,
                            input int nbeats, input bit with_done);
    beat_t b;
    for (int j = 0; j < nbeats; j++) begin
      if (j < N) begin
        b.x = j % W;
        b.y = j / W;
        b.data = j;
      end else begin
        b.x = (j - N) % W;
        b.y = H;
        b.data = 0;
      end
      b.cyc = first + j;
      if (nstall > 0 && b.cyc > stall_at) b.cyc += nstall;
      beat_q.push_back(b);
    end
    if (with_done) done_q.push_back(first + N + FC + nstall);
  endtask

  always @(negedge clk) begin
    beat_t e;
    int    d;
    if (en === 1'b1) begin
      vectors++;
      if (beat_q.size() == 0) begin
        misses++;
        $display("FAIL unexpected_beat @cyc %0d: got x=%0d y=%0d data=%0d expected no beat",
                 cyc, x, y, data);
      end else begin
        e = beat_q.pop_front();
        if (x !== 16'(e.x) || y !== 16'(e.y) || data !== 24'(e.data) || cyc != e.cyc) begin
          misses++;
          $display("FAIL beat%0d: got x=%0d y=%0d data=%0d cyc=%0d expected x=%0d y=%0d data=%0d cyc=%0d",
                   beat_no, x, y, data, cyc, e.x, e.y, e.data, e.cyc);
        end
      end
      beat_no++;
    end
    if (done === 1'b1) begin
      vectors++;
      if (done_q.size() == 0) begin
        misses++;
        $display("FAIL unexpected_done @cyc %0d: got done=1 expected done=0", cyc);
      end else begin
        d = done_q.pop_front();
        if (cyc != d) begin
          misses++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, d);
        end
      end
    end
  end

  initial begin
    // Reset state.
    goto(1);
    chk("rst_en", 32'(en), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    goto(2);
    reset = 1'b0;

    // Plain frame.
    push_frame(8, 0, 0, N + FC, 1'b1);
    goto(5);
    start = 1'b1;
    chk("t1_busy_pre", 32'(busy), 0);
    goto(6);
    start = 1'b0;
    chk("t1_busy_first", 32'(busy), 1);
    chk("t1_prime_addr", 32'(mem_addr), 0);
    goto(8);
    chk("t1_first_en", 32'(en), 1);
    goto(26);
    chk("t1_busy_done", 32'(busy), 1);
    chk("t1_final_addr", 32'(mem_addr), N - 1);
    goto(27);
    chk("t1_busy_after", 32'(busy), 0);

    // Three stall cycles early in the frame.
    push_frame(33, 34, 3, N + FC, 1'b1);
    goto(30);
    start = 1'b1;
    goto(31);
    start = 1'b0;
    goto(34);
    stall = 1'b1;
    goto(37);
    stall = 1'b0;
    chk("t2_stall_en", 32'(en), 0);
    chk("t2_stall_addr", 32'(mem_addr), 2);
    chk("t2_stall_data_hold", 32'(data), 1);

    // Start pulsed mid-stream is ignored.
    push_frame(63, 0, 0, N + FC, 1'b1);
    goto(60);
    start = 1'b1;
    goto(61);
    start = 1'b0;
    goto(66);
    start = 1'b1;
    goto(67);
    start = 1'b0;
    chk("t3_addr_mid", 32'(mem_addr), 5);

    // Reset while pixel 5 is on the output, then replay.
    push_frame(93, 0, 0, 6, 1'b0);
    goto(90);
    start = 1'b1;
    goto(91);
    start = 1'b0;
    goto(98);
    reset = 1'b1;
    goto(99);
    chk("t4_abort_en", 32'(en), 0);
    chk("t4_abort_xy", {x, y}, 0);
    chk("t4_abort_data", 32'(data), 0);
    chk("t4_abort_addr", 32'(mem_addr), 0);
    chk("t4_abort_busy", 32'(busy), 0);
    reset = 1'b0;
    push_frame(105, 0, 0, N + FC, 1'b1);
    goto(102);
    start = 1'b1;
    goto(103);
    start = 1'b0;
    goto(104);
    chk("t4_replay_addr", 32'(mem_addr), 0);

    // Start held high: back-to-back frames with one idle cycle between.
    push_frame(133, 0, 0, N + FC, 1'b1);
    push_frame(155, 0, 0, N + FC, 1'b1);
    goto(130);
    start = 1'b1;
    goto(152);
    chk("t5_gap_busy", 32'(busy), 0);
    chk("t5_gap_en", 32'(en), 0);
    goto(153);
    chk("t5_retrigger_busy", 32'(busy), 1);
    goto(173);
    start = 1'b0;
    goto(175);
    chk("t5_end_busy", 32'(busy), 0);

    goto(185);
    chk("beats_outstanding", 32'(beat_q.size()), 0);
    chk("dones_outstanding", 32'(done_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
